nios_memory_arbiter: RTL

- Two-master, fixed-latency arbiter that shares the single-port 5320x32 on-chip Nios program/data memory between master A (Nios data port) and master B (DMA/video fetch engine).
- Presents an Avalon-MM slave interface with waitrequest/readdatavalid to each master and drives the memory's s1 port.
- Round-robin arbitration with a bounded burst hold; out-of-range accesses are blocked.

---
 rtl/nios_memory_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/nios_memory_arbiter.sv
// nios_memory_arbiter: round-robin two-master Avalon-MM arbiter for a single-port on-chip memory
// with bounded burst hold, one-cycle read latency and out-of-range blocking.
module nios_memory_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 5320,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [3:0]        b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      BURST_LAST = 4'(MAX_BURST - 1);
  state_t     state_q, state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       rr_last_q, rr_last_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_owner_q, pend_owner_d;
  logic       pend_oor_q, pend_oor_d;
  logic       req_a, req_b, gnt_a, gnt_b, sat, same, wr, rd, in_range, rd_acc;
  // Owner/last-winner encoding: 0 = master A, 1 = master B.
  always_comb begin
    req_a           = a_read | a_write;
    req_b           = b_read | b_write;
    sat             = burst_cnt_q == BURST_LAST;
    gnt_a           = reset_n && req_a && (state_q == OWN_A ? !(sat && req_b) :
                                           state_q == OWN_B ? (!req_b || sat) :
                                                              (!req_b || rr_last_q));
    gnt_b           = reset_n && req_b && !gnt_a;
    same            = (gnt_a && state_q == OWN_A) || (gnt_b && state_q == OWN_B);
    state_d         = gnt_a ? OWN_A : gnt_b ? OWN_B : IDLE;
    rr_last_d       = gnt_a ? 1'b0 : gnt_b ? 1'b1 : rr_last_q;
    burst_cnt_d     = !same ? 4'd0 : sat ? burst_cnt_q : burst_cnt_q + 4'd1;
    wr              = gnt_b ? b_write : a_write;
    rd              = gnt_b ? b_read : a_read;
    mem_address     = gnt_b ? b_address : a_address;
    mem_byteenable  = gnt_b ? b_byteenable : a_byteenable;
    mem_writedata   = gnt_b ? b_writedata : a_writedata;
    in_range        = {1'b0, mem_address} < DEPTH_L;
    mem_chipselect  = (gnt_a || gnt_b) && in_range;
    mem_write       = mem_chipselect && wr;
    mem_clken       = reset_n;
    // Write wins over a simultaneous read, so only a pure read creates a pending strobe.
    rd_acc          = (gnt_a || gnt_b) && rd && !wr;
    pend_valid_d    = rd_acc;
    pend_owner_d    = rd_acc ? gnt_b : pend_owner_q;
    pend_oor_d      = rd_acc ? !in_range : pend_oor_q;
    a_waitrequest   = !gnt_a;
    b_waitrequest   = !gnt_b;
    a_readdatavalid = pend_valid_q && !pend_owner_q;
    b_readdatavalid = pend_valid_q && pend_owner_q;
    a_readdata      = (a_readdatavalid && !pend_oor_q) ? mem_readdata : '0;
    b_readdata      = (b_readdatavalid && !pend_oor_q) ? mem_readdata : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      burst_cnt_q  <= 4'd0;
      rr_last_q    <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
      pend_oor_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      rr_last_q    <= rr_last_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      pend_oor_q   <= pend_oor_d;
    end
  end
endmodule
